demux_stream: RTL and testbench

- Parametrised, registered 1-to-NCH stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Routes each accepted input word to the channel given by `in_sel`, or to all channels in broadcast mode.
- Each channel has its own single-entry output register, so a stalled channel blocks only traffic addressed to it.
- Sits between a single producer and NCH independent consumers in the datapath.

---
 rtl/demux_stream.sv | 119 +++++++++++
 tb/tb_demux_stream.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-NCH stream demultiplexer with a valid/ready handshake on the
// input and on every output channel. Each channel owns a single-entry output register, so a
// stalled consumer only blocks words addressed to it.
// Optional build macro DEMUX_STATS_EN enables per-channel 16-bit accepted-word counters;
// without it stat_cnt is tied to zero.
module demux_stream #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 4,
  parameter int unsigned SW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_bcast,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic              drop,
  output logic [NCH*16-1:0] stat_cnt
);

  logic [NCH-1:0]    valid_q;
  logic [NCH*DW-1:0] data_q;
  logic              drop_q;
  logic              drop_d;

  logic [NCH-1:0] chan_free;
  logic [NCH-1:0] load;
  logic           sel_in_range;
  logic           sel_free;
  logic           accept;

  // Channel availability, input ready and per-channel load decode.
  always_comb begin
    chan_free    = ~valid_q | out_ready;
    sel_in_range = 1'b0;
    sel_free     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (in_sel == SW'(i)) begin
        sel_in_range = 1'b1;
        sel_free     = chan_free[i];
      end
    end

    // Out-of-range unicast words are sunk, so they never stall the producer.
    if (in_bcast) begin
      in_ready = &chan_free;
    end else if (sel_in_range) begin
      in_ready = sel_free;
    end else begin
      in_ready = 1'b1;
    end

    accept = in_valid && in_ready;
    for (int i = 0; i < NCH; i++) begin
      load[i] = accept && (in_bcast || (in_sel == SW'(i)));
    end
    drop_d = accept && !in_bcast && !sel_in_range;
  end

  // Per-channel valid flags and the drop pulse; a load wins over a same-cycle drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          valid_q[i] <= 1'b1;
        end else if (out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Per-channel data registers; data holds its last value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          data_q[i*DW +: DW] <= in_data;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop      = drop_q;

`ifdef DEMUX_STATS_EN
  logic [NCH*16-1:0] cnt_q;

  // Accepted-word counters, one per channel, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          cnt_q[i*16 +: 16] <= cnt_q[i*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign stat_cnt = cnt_q;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: a 4-channel instance with a per-channel scoreboard
// and a 3-channel instance for the out-of-range select case.
module tb_demux_stream;

`ifdef DEMUX_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_bcast, drop;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic [63:0] stat_cnt;

  logic        b_in_valid, b_in_ready, b_in_bcast, b_drop;
  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [23:0] b_out_data;
  logic [47:0] b_stat_cnt;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_q [4][$];
  logic [15:0] exp_cnt [4];

  demux_stream #(.DW(8), .NCH(4), .SW(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop(drop), .stat_cnt(stat_cnt)
  );

  demux_stream #(.DW(8), .NCH(3), .SW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .drop(b_drop), .stat_cnt(b_stat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] exp_stat();
    return StatsOn ? {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]} : 64'd0;
  endfunction

  // Scoreboard: every transfer out of a channel must match the oldest expected word.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          vectors++;
          if (exp_q[i].size() == 0) begin
            miscompares++;
            $display("FAIL sb_ch%0d: got 0x%02h, expected no word", i, out_data[i*8 +: 8]);
          end else begin
            e = exp_q[i].pop_front();
            if (out_data[i*8 +: 8] !== e) begin
              miscompares++;
              $display("FAIL sb_ch%0d: got 0x%02h, expected 0x%02h", i, out_data[i*8 +: 8], e);
            end
          end
        end
      end
    end
  end

  // Present a word, wait (bounded) for in_ready, record it, and complete the accept edge.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic bc);
    int n;
    in_data  = d;
    in_sel   = s;
    in_bcast = bc;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready got 0 for 50 cycles, expected 1");
    end else if (bc) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].push_back(d);
        exp_cnt[i]++;
      end
    end else begin
      exp_q[s].push_back(d);
      exp_cnt[s]++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0; in_bcast = 1'b0; out_ready = 4'hF;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_in_sel = 2'd0; b_in_bcast = 1'b0;
    b_out_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 4'h0 || out_data !== 32'h0 || drop !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_hold: got valid=%h data=%h drop=%b, expected 0/0/0",
               out_valid, out_data, drop);
    end
    vectors++;
    if (stat_cnt !== 64'h0 || in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_hold_misc: got stat=%h rdy=%b b_rdy=%b, expected 0/1/1",
               stat_cnt, in_ready, b_in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 4'h0 || out_data !== 32'h0 || drop !== 1'b0 || stat_cnt !== 64'h0
        || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release: got valid=%h data=%h drop=%b stat=%h rdy=%b, expected zeros rdy=1",
               out_valid, out_data, drop, stat_cnt, in_ready);
    end
  endtask

  task automatic test_unicast();
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    send(8'hA5, 2'd2, 1'b0);
    vectors++;
    if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hA5 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL unicast: got valid=%b data2=%h rdy=%b, expected 0100/a5/1",
               out_valid, out_data[23:16], in_ready);
    end
    vectors++;
    if (stat_cnt !== exp_stat()) begin
      miscompares++;
      $display("FAIL unicast_stat: got %h, expected %h", stat_cnt, exp_stat());
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL unicast_drain: got valid=%b, expected 0000", out_valid);
    end
  endtask

  task automatic test_stall();
    @(posedge clk);
    #1;
    out_ready = 4'b1101;
    send(8'h11, 2'd1, 1'b0);
    in_data = 8'h22; in_sel = 2'd1; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h11) begin
      miscompares++;
      $display("FAIL stall_block: got rdy=%b v1=%b d1=%h, expected 0/1/11",
               in_ready, out_valid[1], out_data[15:8]);
    end
    @(posedge clk);
    #1;
    send(8'h33, 2'd3, 1'b0);
    vectors++;
    if (out_valid[3] !== 1'b1 || out_data[31:24] !== 8'h33 || out_data[15:8] !== 8'h11
        || out_valid[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_bypass: got v=%b d3=%h d1=%h, expected v1,v3 set d3=33 d1=11",
               out_valid, out_data[31:24], out_data[15:8]);
    end
    in_data = 8'h22; in_sel = 2'd1; in_valid = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_still: got rdy=%b, expected 0", in_ready);
    end
    out_ready = 4'hF;
    send(8'h22, 2'd1, 1'b0);
    vectors++;
    if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h22) begin
      miscompares++;
      $display("FAIL stall_release: got v1=%b d1=%h, expected 1/22", out_valid[1], out_data[15:8]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL stall_drain: got valid=%b, expected 0000", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    out_ready = 4'hF; in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 8'(k);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready%0d: got %b, expected 1", k, in_ready);
      end
      exp_q[0].push_back(8'(k));
      exp_cnt[0]++;
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'(k)) begin
        miscompares++;
        $display("FAIL b2b_out%0d: got v0=%b d0=%h, expected 1/%h", k, out_valid[0],
                 out_data[7:0], 8'(k));
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid[0] !== 1'b0 || exp_q[0].size() != 0) begin
      miscompares++;
      $display("FAIL b2b_end: got v0=%b pending=%0d, expected 0/0", out_valid[0], exp_q[0].size());
    end
  endtask

  task automatic test_bcast();
    @(posedge clk);
    #1;
    out_ready = 4'b0111;
    send(8'h77, 2'd3, 1'b0);
    in_data = 8'h5A; in_bcast = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bcast_block: got rdy=%b, expected 0", in_ready);
      end
      @(posedge clk);
    end
    #1;
    out_ready = 4'hF;
    send(8'h5A, 2'd0, 1'b1);
    vectors++;
    if (out_valid !== 4'hF || out_data !== {4{8'h5A}}) begin
      miscompares++;
      $display("FAIL bcast_out: got v=%b d=%h, expected f/5a5a5a5a", out_valid, out_data);
    end
    vectors++;
    if (stat_cnt !== exp_stat()) begin
      miscompares++;
      $display("FAIL bcast_stat: got %h, expected %h", stat_cnt, exp_stat());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drop();
    @(posedge clk);
    #1;
    b_out_ready = 3'b101;
    b_in_data = 8'h44; b_in_sel = 2'd1; b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_data = 8'h99; b_in_sel = 2'd3;
    #1;
    vectors++;
    if (b_in_ready !== 1'b1 || b_drop !== 1'b0 || b_out_valid !== 3'b010) begin
      miscompares++;
      $display("FAIL drop_pre: got rdy=%b drop=%b v=%b, expected 1/0/010",
               b_in_ready, b_drop, b_out_valid);
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    vectors++;
    if (b_drop !== 1'b1 || b_out_valid !== 3'b010 || b_out_data[15:8] !== 8'h44) begin
      miscompares++;
      $display("FAIL drop_pulse: got drop=%b v=%b d1=%h, expected 1/010/44",
               b_drop, b_out_valid, b_out_data[15:8]);
    end
    vectors++;
    if (b_stat_cnt !== (StatsOn ? {16'd0, 16'd1, 16'd0} : 48'd0)) begin
      miscompares++;
      $display("FAIL drop_stat: got %h, expected ch1 count only", b_stat_cnt);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (b_drop !== 1'b0 || b_out_valid !== 3'b010) begin
      miscompares++;
      $display("FAIL drop_once: got drop=%b v=%b, expected 0/010", b_drop, b_out_valid);
    end
    b_out_ready = 3'b111;
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    out_ready = 4'h0;
    send(8'hC1, 2'd0, 1'b0);
    send(8'hC2, 2'd1, 1'b0);
    send(8'hC3, 2'd2, 1'b0);
    in_data = 8'hC4; in_sel = 2'd0; in_valid = 1'b1;
    vectors++;
    if (out_valid !== 4'b0111) begin
      miscompares++;
      $display("FAIL mid_fill: got v=%b, expected 0111", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 4'h0 || out_data !== 32'h0 || drop !== 1'b0 || stat_cnt !== 64'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b d=%h drop=%b stat=%h, expected all 0",
               out_valid, out_data, drop, stat_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      exp_cnt[i] = 16'd0;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 4'hF;
    @(negedge clk);
    vectors++;
    if (out_valid !== 4'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_release: got v=%b rdy=%b, expected 0/1", out_valid, in_ready);
    end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_wrap();
    @(posedge clk);
    #1;
    out_ready = 4'hF; in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      in_data = k[7:0];
      exp_q[0].push_back(k[7:0]);
      exp_cnt[0]++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (stat_cnt[15:0] !== 16'd1 || stat_cnt !== exp_stat()) begin
      miscompares++;
      $display("FAIL wrap: got %h, expected ch0=0001 (%h)", stat_cnt, exp_stat());
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 16'd0;
    test_reset();
    test_unicast();
    test_stall();
    test_back_to_back();
    test_bcast();
    test_drop();
    test_reset_mid();
`ifdef DEMUX_STATS_EN
    test_wrap();
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("FAIL final_ch%0d: got %0d undelivered words, expected 0", i, exp_q[i].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
